// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame/baud constants
// common to uart_rx and uart_tx.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 1302;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs; both stages reset high
// so an idle-high serial line never looks like a start edge out of reset.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxPin, validates the start bit at half-bit,
// samples data at mid-bit and strobes valid or frameErr at the stop bit.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | line idle, waiting for rx_s low
//   START | timing half a bit to recheck the start bit (glitch filter)
//   DATA  | sampling 8 data bits, LSB first, one per bit period
//   STOP  | sampling the stop bit; high -> valid, low -> frameErr
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxPin,
    output logic [7:0] data,
    output logic       valid,
    output logic       frameErr,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t      state, state_nxt;
    logic           rx_s;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  bit_idx;
    logic [7:0]     shift_reg;

    logic           cnt_clr;
    logic           idx_clr;
    logic           shift_en;
    logic           load_data;
    logic           set_err;

    sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rxPin),
        .q     (rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every transition clears the cycle counter, so each state times from zero.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        load_data = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        idx_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        load_data = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            if (cnt_clr || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + BW'(1);
            end

            // LSB arrives first, so shifting in at the top leaves it in bit 0.
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
            end

            if (load_data) begin
                data <= shift_reg;
            end
            valid    <= load_data;
            frameErr <= set_err;
        end
    end

    assign busy = (state != IDLE);

endmodule
